spi_reg_bank: RTL
=================

# spi_reg_bank

Configuration register bank on the SPI slave's parallel side, directly downstream of the address/byte decoder. Each decoded byte arrives as a one-cycle strobe carrying `is_write`, `addr` and `wdata`. The block commits writes into a bank of read/write registers, returns the addressed read data to the serializer, exposes all register contents to the chip core, and counts illegal writes.

## Interface
- `NUM_RW`, default 32: number of 8-bit read/write registers, at addresses 0..NUM_RW-1.
- `NUM_RO`, default 4: number of 8-bit read-only status registers, at addresses NUM_RW..NUM_RW+NUM_RO-1. NUM_RW+NUM_RO ≤ 128.
- `RESET_VAL`, default 8'h00: reset value of every RW register.

Ports:
- `spi_clk` in 1: the single clock. The block uses one clock; reset is synchronous and active-low.
- `rstn` in 1: synchronous active-low reset, sampled on posedge `spi_clk`.
- `cs` in 1: chip select, active high. Sampled synchronously; low means no transaction.
- `byte_valid` in 1: one-cycle pulse. `is_write`/`addr`/`wdata` are valid in the same cycle.
- `is_write` in 1: transaction direction, 1 = write.
- `addr` in 7: register address for this byte.
- `wdata` in 8: write data for this byte. Ignored on the header byte.
- `status_in` in NUM_RO*8: live status values. Byte i maps to address NUM_RW+i.
- `regs_out` out NUM_RW*8: all RW register contents. Byte i is address i.
- `rdata` out 8: read data for the serializer.
- `rdata_valid` out 1: one-cycle pulse when `rdata` is updated.
- `wr_stb` out 1: one-cycle pulse when an RW register is written.
- `wr_addr` out 7: address of the last committed write.
- `wr_err_cnt` out 8: saturating count of illegal writes.

## Operation
- **FSM states:** IDLE, HEADER, DATA.
  - IDLE → HEADER when `cs`=1.
  - HEADER → DATA on `byte_valid`.
  - DATA stays in DATA on `byte_valid`.
  - Any state → IDLE whenever `cs`=0. The `cs`=0 check has priority over `byte_valid`.
- **IDLE:** `byte_valid` is ignored. No writes, no `rdata_valid`, no counting.
- **HEADER byte** (first `byte_valid` after `cs` rises):
  - Never writes.
  - Loads `rdata` with the read value of `addr` and pulses `rdata_valid`.
- **DATA byte:**
  - Always loads `rdata` with the read value of `addr` (the pre-write value) and pulses `rdata_valid`.
  - If `is_write`=1 and `addr` < NUM_RW: store `wdata` into register `addr`, pulse `wr_stb`, set `wr_addr`=`addr`.
  - If `is_write`=1 and `addr` ≥ NUM_RW (read-only or unmapped): no register change, no `wr_stb`, `wr_err_cnt` += 1, saturating at 8'hFF.
- **Read value** of an address:
  - 0..NUM_RW-1: the RW register.
  - NUM_RW..NUM_RW+NUM_RO-1: `status_in`, sampled in the strobe cycle.
  - Above that: 8'h00.
- **Read and write to the same address on the same strobe:** `rdata` gets the old value.
- **`rdata` and `wr_addr`** hold their values between strobes and across `cs` deassertion.
- **RW registers** retain their contents across transactions. Only `rstn` restores `RESET_VAL`.

## Timing
- **Reset values** (`rstn`=0 at a posedge):
  - every RW register = `RESET_VAL`
  - `rdata` = 8'h00, `rdata_valid` = 0
  - `wr_stb` = 0, `wr_addr` = 7'h00
  - `wr_err_cnt` = 8'h00
  - FSM = IDLE
- Reset has priority over all other inputs, including a `byte_valid` in the same cycle.
- **Latency:** for `byte_valid` sampled at edge t:
  - `rdata`, `rdata_valid`, `wr_stb`, `wr_addr` and `wr_err_cnt` update at edge t+1.
  - `regs_out` reflects the write after edge t+1.
- `rdata_valid` and `wr_stb` are high for exactly one cycle per accepted strobe.
- **Back-to-back strobes** on consecutive cycles are each fully processed. There is no stall and no back-pressure.
- **`cs` rising with `byte_valid` in the same cycle:** FSM moves to HEADER only; that strobe is ignored.
- **`cs` falling in the middle of a byte:** FSM goes to IDLE at the next edge. No partial write ever occurs because writes happen only on strobes.
- **All outputs are registered.** `rdata`, `rdata_valid`, `wr_stb` and `wr_addr` have no combinational path from any input.

## Test plan
- **Reset:** RESET_VAL=8'hA5, hold `rstn`=0 for 2 cycles while driving `byte_valid` → all `regs_out` bytes = 8'hA5, `rdata`=0, `wr_err_cnt`=0, no pulses.
- **Write burst:** `cs`=1, header strobe (addr=5, `is_write`=1), then strobes addr=6/`wdata`=8'h3C and addr=7/`wdata`=8'hC3 →
  - reg 5 unchanged;
  - reg6=8'h3C, reg7=8'hC3;
  - two `wr_stb` pulses with `wr_addr`=6 then 7;
  - three `rdata_valid` pulses.
- **Read:** after the write burst, header strobe addr=6 with `is_write`=0 → `rdata`=8'h3C one cycle later. Then a strobe at addr=33 with `status_in` byte 1 = 8'h5A → `rdata`=8'h5A.
- **Illegal writes:** write strobes to addr=32 and addr=100 → no register change, no `wr_stb`. `wr_err_cnt`=2. After 300 such strobes, `wr_err_cnt`=8'hFF.
- **Same-address read/write:** reg 3 = 8'h11, DATA strobe write addr=3/`wdata`=8'h22 → `rdata`=8'h11 and reg3=8'h22.
- **`cs` drop and mid-transaction reset:**
  - Drop `cs` for one cycle between data strobes → the next strobe is treated as a header (no write).
  - Assert `rstn`=0 in the same cycle as a DATA write strobe → register shows `RESET_VAL`, no `wr_stb`.

Source files
------------

// File: rtl/spi_reg_bank.sv
// Configuration register bank behind the SPI slave byte decoder.
// Takes one-cycle byte strobes and commits writes to the RW registers.
// Returns registered read data for every accepted strobe.
// Counts writes aimed at read-only or unmapped addresses; the count saturates.
module spi_reg_bank #(
    parameter int         NUM_RW    = 32,
    parameter int         NUM_RO    = 4,
    parameter logic [7:0] RESET_VAL = 8'h00
) (
    input  logic                spi_clk,
    input  logic                rstn,
    input  logic                cs,
    input  logic                byte_valid,
    input  logic                is_write,
    input  logic [6:0]          addr,
    input  logic [7:0]          wdata,
    input  logic [NUM_RO*8-1:0] status_in,
    output logic [NUM_RW*8-1:0] regs_out,
    output logic [7:0]          rdata,
    output logic                rdata_valid,
    output logic                wr_stb,
    output logic [6:0]          wr_addr,
    output logic [7:0]          wr_err_cnt
);

    typedef enum logic [1:0] {IDLE, HEADER, DATA} state_t;

    state_t              state;
    state_t              state_next;
    logic [NUM_RW*8-1:0] regs_q;
    logic [7:0]          rd_val;
    logic                accept;
    logic                in_rw;
    logic                wr_hit;
    logic                wr_err;

    // Saturating increment for the illegal-write counter.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? 8'hFF : v + 8'h01;
    endfunction

    // FSM state register.
    always_ff @(posedge spi_clk) begin
        if (!rstn) state <= IDLE;
        else       state <= state_next;
    end

    // Next state and strobe qualification; cs low always wins.
    // A strobe that arrives while the FSM is still in IDLE is dropped.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        if (!cs) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    state_next = HEADER;
                HEADER:  if (byte_valid) begin
                             state_next = DATA;
                             accept     = 1'b1;
                         end
                DATA:    accept = byte_valid;
                default: state_next = IDLE;
            endcase
        end
    end

    // Write decode: only DATA bytes may write.
    // Writes above the RW range are counted as errors instead of being committed.
    always_comb begin
        in_rw  = ({1'b0, addr} < 8'(NUM_RW));
        wr_hit = accept && (state == DATA) && is_write && in_rw;
        wr_err = accept && (state == DATA) && is_write && !in_rw;
    end

    // Read mux: RW register, then live status, then zero for unmapped addresses.
    always_comb begin
        rd_val = 8'h00;
        for (int i = 0; i < NUM_RW; i++)
            if (addr == 7'(i)) rd_val = regs_q[i*8 +: 8];
        for (int i = 0; i < NUM_RO; i++)
            if ({1'b0, addr} == 8'(NUM_RW + i)) rd_val = status_in[i*8 +: 8];
    end

    // RW register storage; a write lands one edge after its strobe.
    always_ff @(posedge spi_clk) begin
        if (!rstn) begin
            regs_q <= {NUM_RW{RESET_VAL}};
        end else if (wr_hit) begin
            for (int i = 0; i < NUM_RW; i++)
                if (addr == 7'(i)) regs_q[i*8 +: 8] <= wdata;
        end
    end

    // Registered response outputs.
    // rdata captures the pre-write value, so a read-modify on the same address sees old data.
    always_ff @(posedge spi_clk) begin
        if (!rstn) begin
            rdata       <= 8'h00;
            rdata_valid <= 1'b0;
            wr_stb      <= 1'b0;
            wr_addr     <= 7'h00;
            wr_err_cnt  <= 8'h00;
        end else begin
            rdata_valid <= accept;
            wr_stb      <= wr_hit;
            if (accept) rdata      <= rd_val;
            if (wr_hit) wr_addr    <= addr;
            if (wr_err) wr_err_cnt <= sat_inc(wr_err_cnt);
        end
    end

    assign regs_out = regs_q;

endmodule
